cordic_octant_out: RTL and testbench

- Output stage of the CORDIC pipeline: folds the final X/Y rotation result back to the full circle using the 3-bit octant code carried down the pipeline, and produces signed cos/sin.
- Successor to the fixed 22-to-16-bit output stage: parametrised widths, two-stage elastic valid/ready pipeline, asynchronous reset, saturating negation and a saturation event counter.
- Sits between the last CORDIC iteration stage and the downstream consumer (NCO/mixer).

---
 rtl/cordic_octant_out.sv | 180 ++++++++++++++++++
 tb/tb_cordic_octant_out.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_octant_out.sv
// cordic_octant_out: CORDIC output stage.
// Folds the final X/Y rotation result back to the full circle using the
// 3-bit octant code. Output is signed cos/sin with saturating negation.
// The datapath is a two-stage elastic pipeline (A: truncate/round, B: fold).
//
// Valid/ready contract: a word moves across an interface on a rising clock
// edge where valid && ready are both high. A producer holding valid keeps its
// data stable until that edge. in_ready is combinational from the stage
// valids and out_ready. out_valid/cos_out/sin_out/sat_flag are registered and
// held while out_valid && !out_ready.
//
// Optional build macro: CORDIC_OUT_ROUND_EN. When it is defined, stage A
// rounds half-up with positive clamp. When it is undefined, stage A
// truncates.
module cordic_octant_out #(
  parameter int IN_W  = 22,
  parameter int OUT_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  x_in,
  input  logic [IN_W-1:0]  y_in,
  input  logic [2:0]       octant,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] cos_out,
  output logic [OUT_W-1:0] sin_out,
  output logic             sat_flag,
  output logic [CNT_W-1:0] sat_cnt,
  input  logic             sat_clr
);

  localparam logic [OUT_W-1:0] MAX_V = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MIN_V = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] ONE_W = {{(OUT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};

  // Stage A registers
  logic             va;
  logic [OUT_W-1:0] xa, ya;
  logic [2:0]       oa;
  logic             sa;

  // Stage B registers (drive the outputs directly)
  logic             vb;
  logic [OUT_W-1:0] cos_q, sin_q;
  logic             flag_q;

  // Handshake
  logic a_load, b_load, out_xfer;

  assign in_ready = !va || !vb || out_ready;
  assign a_load   = in_valid && in_ready;
  assign b_load   = va && (!vb || out_ready);
  assign out_xfer = vb && out_ready;

  // Low input bits below the output precision are dropped in truncation mode.
  logic unused_lsbs;
  assign unused_lsbs = ^{x_in[IN_W-OUT_W-1:0], y_in[IN_W-OUT_W-1:0]};

  // Stage A input quantisation: truncate or round half-up with clamp.
  logic [OUT_W-1:0] xt, yt;
  logic             rnd_sat;

`ifdef CORDIC_OUT_ROUND_EN
  logic [OUT_W-1:0] x_tr, y_tr;
  logic             x_half, y_half;
  logic             x_clamp, y_clamp;

  assign x_tr   = x_in[IN_W-1 -: OUT_W];
  assign y_tr   = y_in[IN_W-1 -: OUT_W];
  assign x_half = x_in[IN_W-OUT_W-1];
  assign y_half = y_in[IN_W-OUT_W-1];

  // Round half-up; only the largest positive code can overflow.
  always_comb begin
    x_clamp = x_half && (x_tr == MAX_V);
    y_clamp = y_half && (y_tr == MAX_V);
    xt      = x_clamp ? MAX_V : x_tr + (x_half ? ONE_W : '0);
    yt      = y_clamp ? MAX_V : y_tr + (y_half ? ONE_W : '0);
    rnd_sat = x_clamp || y_clamp;
  end
`else
  // Plain truncation to the top OUT_W bits.
  always_comb begin
    xt      = x_in[IN_W-1 -: OUT_W];
    yt      = y_in[IN_W-1 -: OUT_W];
    rnd_sat = 1'b0;
  end
`endif

  // Stage A: capture quantised X/Y and the octant on an input transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      va <= 1'b0;
      xa <= '0;
      ya <= '0;
      oa <= '0;
      sa <= 1'b0;
    end else if (a_load) begin
      va <= 1'b1;
      xa <= xt;
      ya <= yt;
      oa <= octant;
      sa <= rnd_sat;
    end else if (b_load) begin
      va <= 1'b0;
    end
  end

  // Saturating negation of the stage-A values.
  logic [OUT_W-1:0] nx, ny;
  logic             nx_sat, ny_sat;

  // Negating the most negative code clamps to the largest positive code.
  always_comb begin
    nx_sat = (xa == MIN_V);
    ny_sat = (ya == MIN_V);
    nx     = nx_sat ? MAX_V : (~xa) + ONE_W;
    ny     = ny_sat ? MAX_V : (~ya) + ONE_W;
  end

  // Octant fold: choose operand order and sign.
  logic [OUT_W-1:0] cos_d, sin_d;
  logic             flag_d;

  // Only a negation that reaches the output contributes to the flag.
  always_comb begin
    cos_d  = xa;
    sin_d  = ya;
    flag_d = sa;
    case (oa)
      3'b000: begin cos_d = xa; sin_d = ya; end
      3'b001: begin cos_d = ya; sin_d = xa; end
      3'b010: begin cos_d = ny; sin_d = xa; flag_d = sa || ny_sat; end
      3'b011: begin cos_d = nx; sin_d = ya; flag_d = sa || nx_sat; end
      3'b100: begin cos_d = nx; sin_d = ny; flag_d = sa || nx_sat || ny_sat; end
      3'b101: begin cos_d = ny; sin_d = nx; flag_d = sa || nx_sat || ny_sat; end
      3'b110: begin cos_d = ya; sin_d = nx; flag_d = sa || nx_sat; end
      default: begin cos_d = xa; sin_d = ny; flag_d = sa || ny_sat; end
    endcase
  end

  // Stage B: load the folded word, or empty after the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vb     <= 1'b0;
      cos_q  <= '0;
      sin_q  <= '0;
      flag_q <= 1'b0;
    end else if (b_load) begin
      vb     <= 1'b1;
      cos_q  <= cos_d;
      sin_q  <= sin_d;
      flag_q <= flag_d;
    end else if (out_xfer) begin
      vb <= 1'b0;
    end
  end

  // Saturation event counter: clear wins; sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt <= '0;
    end else if (sat_clr) begin
      sat_cnt <= '0;
    end else if (out_xfer && flag_q && (sat_cnt != {CNT_W{1'b1}})) begin
      sat_cnt <= sat_cnt + ONE_C;
    end
  end

  assign out_valid = vb;
  assign cos_out   = cos_q;
  assign sin_out   = sin_q;
  assign sat_flag  = flag_q;

endmodule

// File: tb/tb_cordic_octant_out.sv
// Directed bench for cordic_octant_out (default widths 22 -> 16, 8-bit count).
module tb_cordic_octant_out;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [21:0] x_in;
  logic [21:0] y_in;
  logic [2:0]  octant;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] cos_out;
  logic [15:0] sin_out;
  logic        sat_flag;
  logic [7:0]  sat_cnt;
  logic        sat_clr;

  int tests_run;
  int tests_failed;

  // Scoreboard of expected {cos, sin} for the streaming test
  logic [31:0] exp_q[$];

  cordic_octant_out dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .octant    (octant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cos_out   (cos_out),
    .sin_out   (sin_out),
    .sat_flag  (sat_flag),
    .sat_cnt   (sat_cnt),
    .sat_clr   (sat_clr)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Send one word with out_ready high and check latency and result.
  task automatic send_word(input logic [21:0] x, input logic [21:0] y, input logic [2:0] oct,
                           input logic [15:0] ec, input logic [15:0] es, input logic ef,
                           input string tag);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    x_in     = x;
    y_in     = y;
    octant   = oct;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 33'(n), 33'd2);
    chk({tag, "_cos"}, 33'(cos_out), 33'(ec));
    chk({tag, "_sin"}, 33'(sin_out), 33'(es));
    chk({tag, "_flag"}, 33'(sat_flag), 33'(ef));
  endtask

  logic [15:0] oct_cos[8] = '{16'h3FFF, 16'h1000, 16'hF000, 16'hC001,
                              16'hC001, 16'hF000, 16'h1000, 16'h3FFF};
  logic [15:0] oct_sin[8] = '{16'h1000, 16'h3FFF, 16'h3FFF, 16'h1000,
                              16'hF000, 16'hC001, 16'hC001, 16'hF000};

  initial begin
    int sent;
    int got;
    int cyc;
    logic saw_full;
    logic held_v;
    logic [32:0] held;

    tests_run    = 0;
    tests_failed = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    x_in      = '0;
    y_in      = '0;
    octant    = '0;
    out_ready = 1'b1;
    sat_clr   = 1'b0;

    // Reset then idle
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 33'(out_valid), 33'd0);
    chk("rst_cos", 33'(cos_out), 33'd0);
    chk("rst_sin", 33'(sin_out), 33'd0);
    chk("rst_flag", 33'(sat_flag), 33'd0);
    chk("rst_sat_cnt", 33'(sat_cnt), 33'd0);
    chk("rst_in_ready", 33'(in_ready), 33'd1);

    // All eight octants: xt = 16'h3FFF, yt = 16'h1000
    for (int i = 0; i < 8; i++) begin
      send_word(22'h0FFFC0, 22'h040000, 3'(i), oct_cos[i], oct_sin[i], 1'b0,
                $sformatf("oct%0d", i));
    end
    @(negedge clk);
    chk("oct_sat_cnt", 33'(sat_cnt), 33'd0);

    // Negation of the most negative value saturates
    send_word(22'h200000, 22'h000000, 3'b011, 16'h7FFF, 16'h0000, 1'b1, "negsat");
    @(negedge clk);
    chk("negsat_cnt", 33'(sat_cnt), 33'd1);

    // sat_clr in the same cycle as a saturated transfer
    in_valid = 1'b1;
    x_in     = 22'h200000;
    y_in     = 22'h000000;
    octant   = 3'b011;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("clr_word_valid", 33'(out_valid), 33'd1);
    chk("clr_word_flag", 33'(sat_flag), 33'd1);
    sat_clr = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;
    chk("clr_priority", 33'(sat_cnt), 33'd0);

    // Stream of 10 words, consumer stalled in cycles 3..6
    sent = 0; got = 0; cyc = 0;
    saw_full = 1'b0; held_v = 1'b0; held = '0;
    while (got < 10 && cyc < 60) begin
      @(negedge clk);
      out_ready = !(cyc >= 3 && cyc <= 6);
      if (sent < 10) begin
        in_valid = 1'b1;
        x_in     = {16'h0100 + sent[15:0], 6'h15};
        y_in     = {16'h0200 + sent[15:0], 6'h1A};
        octant   = 3'b000;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (held_v && out_valid) chk("stall_hold", {sat_flag, cos_out, sin_out}, held);
      held_v = 1'b0;
      if (out_valid && !out_ready) begin
        held_v = 1'b1;
        held   = {sat_flag, cos_out, sin_out};
      end
      if (!in_ready) saw_full = 1'b1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("stream_extra", 33'd1, 33'd0);
        else chk("stream_word", {1'b0, cos_out, sin_out}, {1'b0, exp_q.pop_front()});
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({16'h0100 + sent[15:0], 16'h0200 + sent[15:0]});
        sent++;
      end
      cyc++;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stream_backpressure", 33'(saw_full), 33'd1);
    chk("stream_got", 33'(got), 33'd10);
    chk("stream_sent", 33'(sent), 33'd10);
    chk("stream_leftover", 33'(exp_q.size()), 33'd0);

    // 300 saturating words: counter sticks at all-ones
    sat_clr = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;
    chk("sat300_start", 33'(sat_cnt), 33'd0);
    in_valid = 1'b1;
    x_in     = 22'h200000;
    y_in     = 22'h000000;
    octant   = 3'b011;
    repeat (300) @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("sat300_cnt", 33'(sat_cnt), 33'hFF);

`ifdef CORDIC_OUT_ROUND_EN
    send_word(22'h000020, 22'h000000, 3'b000, 16'h0001, 16'h0000, 1'b0, "round_up");
    send_word(22'h1FFFE0, 22'h000000, 3'b000, 16'h7FFF, 16'h0000, 1'b1, "round_clamp");
`else
    send_word(22'h000020, 22'h000000, 3'b000, 16'h0000, 16'h0000, 1'b0, "trunc_half");
    send_word(22'h1FFFE0, 22'h000000, 3'b000, 16'h7FFF, 16'h0000, 1'b0, "trunc_top");
`endif

    // Reset while two words are in flight
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    x_in      = {16'h1111, 6'h00};
    y_in      = {16'h2222, 6'h00};
    octant    = 3'b000;
    @(posedge clk);
    #1;
    x_in = {16'h3333, 6'h00};
    y_in = {16'h4444, 6'h00};
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("flight_valid", 33'(out_valid), 33'd1);
    chk("flight_full", 33'(in_ready), 33'd0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 33'(out_valid), 33'd0);
    chk("async_rst_cos", 33'(cos_out), 33'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("flushed_no_output", 33'(out_valid), 33'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
